// File: rtl/program_counter_stack.sv
// Sequencer PC with stall, jump, branch and call/return via a LIFO stack.
// Define PC_TRAP_EN to redirect stack faults to TRAP_VECTOR with a trap pulse.
module program_counter_stack #(
  parameter int PC_W        = 8,
  parameter int STEP        = 1,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4,
  parameter int TRAP_VECTOR = 'hF0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             jump,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [PC_W-1:0]                  target,
  input  logic [PC_W-1:0]                  offset,
  output logic [PC_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_empty,
  output logic                             stack_full,
  output logic                             err_ovf,
  output logic                             err_unf,
  output logic                             trap
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
  localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VECTOR);
  localparam logic [SP_W-1:0] DEPTH_V = SP_W'(STACK_DEPTH);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [PC_W-1:0] stk [2**IX_W];

  logic [PC_W-1:0] pc_q, pc_n;
  logic [SP_W-1:0] sp_q, sp_n;
  logic            ovf_q, ovf_n;
  logic            unf_q, unf_n;
  logic            trap_q;
  logic            fault;
  logic            push;
  logic            empty;
  logic            full;
  logic [PC_W-1:0] seq_pc;
  logic [IX_W-1:0] push_ix;
  logic [IX_W-1:0] pop_ix;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == DEPTH_V);
  assign seq_pc  = pc_q + STEP_V;
  assign push_ix = IX_W'(sp_q);
  assign pop_ix  = IX_W'(sp_q - 1'b1);

  // Highest active strobe wins; the rest are dropped.
  always_comb begin
    pc_n  = seq_pc;
    sp_n  = sp_q;
    ovf_n = ovf_q;
    unf_n = unf_q;
    push  = 1'b0;
    fault = 1'b0;
    if (stall) begin
      pc_n = pc_q;
    end else if (ret) begin
      if (empty) begin
        unf_n = 1'b1;
        fault = 1'b1;
      end else begin
        pc_n = stk[pop_ix];
        sp_n = sp_q - 1'b1;
      end
    end else if (call) begin
      pc_n = target;
      if (full) begin
        ovf_n = 1'b1;
        fault = 1'b1;
      end else begin
        push = 1'b1;
        sp_n = sp_q + 1'b1;
      end
    end else if (jump) begin
      pc_n = target;
    end else if (branch) begin
      pc_n = pc_q + offset;
    end
    if (TRAP_EN && fault) pc_n = TRAP_PC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RST_PC;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_n;
      sp_q   <= sp_n;
      ovf_q  <= ovf_n;
      unf_q  <= unf_n;
      trap_q <= fault;
    end
  end

  // Stack contents need no reset: entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stk[push_ix] <= seq_pc;
  end

  assign pc          = pc_q;
  assign sp          = sp_q;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign trap        = TRAP_EN & trap_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (default params).
// Expectations follow PC_TRAP_EN when it is defined.
module tb_program_counter_stack;

  logic       clk;
  logic       reset;
  logic       stall, jump, branch, call, ret;
  logic [7:0] target, offset;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       stack_empty, stack_full;
  logic       err_ovf, err_unf, trap;

  int vec;
  int bad;

`ifdef PC_TRAP_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  program_counter_stack dut (
    .clk(clk), .reset(reset),
    .stall(stall), .jump(jump),
    .branch(branch), .call(call),
    .ret(ret), .target(target),
    .offset(offset), .pc(pc), .sp(sp),
    .stack_empty(stack_empty),
    .stack_full(stack_full),
    .err_ovf(err_ovf),
    .err_unf(err_unf), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {stall, jump, branch, call, ret} = '0;
  endtask

  task automatic go_to(input logic [7:0] a);
    idle();
    jump = 1'b1;
    target = a;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    target = '0;
    offset = '0;
    reset = 1'b0;
    tick();
    vec++;
    if (pc !== 8'h00) begin
      bad++;
      $display("FAIL rst_pc got %h exp 00", pc);
    end
    vec++;
    if (sp !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      bad++;
      $display("FAIL rst_sp got %0d/%b/%b exp 0/1/0", sp, stack_empty, stack_full);
    end
    vec++;
    if ({err_ovf, err_unf, trap} !== 3'b000) begin
      bad++;
      $display("FAIL rst_err got %b exp 000", {err_ovf, err_unf, trap});
    end
    reset = 1'b1;
  endtask

  task automatic test_increment();
    logic [7:0] exp;
    int errs;
    exp = 8'h00;
    errs = 0;
    for (int i = 0; i < 260; i++) begin
      tick();
      exp = exp + 8'd1;
      vec++;
      if (pc !== exp) begin
        bad++;
        errs++;
        if (errs < 5) $display("FAIL inc[%0d] got %h exp %h", i, pc, exp);
      end
    end
    vec++;
    if (pc !== 8'h04 || sp !== 3'd0) begin
      bad++;
      $display("FAIL inc_end got %h/%0d exp 04/0", pc, sp);
    end
  endtask

  task automatic test_branch();
    go_to(8'h10);
    vec++;
    if (pc !== 8'h10) begin
      bad++;
      $display("FAIL br_setup got %h exp 10", pc);
    end
    branch = 1'b1;
    offset = 8'hFD;
    tick();
    idle();
    vec++;
    if (pc !== 8'h0D) begin
      bad++;
      $display("FAIL br_neg got %h exp 0D", pc);
    end
    tick();
    vec++;
    if (pc !== 8'h0E) begin
      bad++;
      $display("FAIL br_next got %h exp 0E", pc);
    end
    go_to(8'hF8);
    branch = 1'b1;
    offset = 8'h0A;
    tick();
    idle();
    vec++;
    if (pc !== 8'h02) begin
      bad++;
      $display("FAIL br_wrap got %h exp 02", pc);
    end
  endtask

  task automatic test_stall();
    go_to(8'h05);
    stall = 1'b1;
    jump = 1'b1;
    target = 8'h40;
    tick();
    vec++;
    if (pc !== 8'h05) begin
      bad++;
      $display("FAIL stall_jmp got %h exp 05", pc);
    end
    jump = 1'b0;
    call = 1'b1;
    tick();
    vec++;
    if (pc !== 8'h05 || sp !== 3'd0) begin
      bad++;
      $display("FAIL stall_call got %h/%0d exp 05/0", pc, sp);
    end
    stall = 1'b0;
    call = 1'b0;
    jump = 1'b1;
    tick();
    idle();
    vec++;
    if (pc !== 8'h40) begin
      bad++;
      $display("FAIL unstall_jmp got %h exp 40", pc);
    end
  endtask

  task automatic test_call_ret();
    go_to(8'h20);
    call = 1'b1;
    target = 8'h80;
    tick();
    idle();
    vec++;
    if (pc !== 8'h80 || sp !== 3'd1 || stack_empty !== 1'b0) begin
      bad++;
      $display("FAIL call got %h/%0d/%b exp 80/1/0", pc, sp, stack_empty);
    end
    ret = 1'b1;
    tick();
    idle();
    vec++;
    if (pc !== 8'h21 || sp !== 3'd0 || stack_empty !== 1'b1) begin
      bad++;
      $display("FAIL ret got %h/%0d/%b exp 21/0/1", pc, sp, stack_empty);
    end
  endtask

  task automatic test_priority();
    go_to(8'h30);
    call = 1'b1;
    jump = 1'b1;
    target = 8'h50;
    tick();
    idle();
    vec++;
    if (pc !== 8'h50 || sp !== 3'd1) begin
      bad++;
      $display("FAIL pri_call got %h/%0d exp 50/1", pc, sp);
    end
    jump = 1'b1;
    branch = 1'b1;
    target = 8'h60;
    offset = 8'h05;
    tick();
    idle();
    vec++;
    if (pc !== 8'h60) begin
      bad++;
      $display("FAIL pri_jmp got %h exp 60", pc);
    end
    ret = 1'b1;
    call = 1'b1;
    target = 8'h70;
    tick();
    idle();
    vec++;
    if (pc !== 8'h31 || sp !== 3'd0) begin
      bad++;
      $display("FAIL pri_ret got %h/%0d exp 31/0", pc, sp);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] rets [4];
    rets[0] = 8'h31;
    rets[1] = 8'h21;
    rets[2] = 8'h11;
    rets[3] = 8'h01;
    go_to(8'h00);
    for (int i = 1; i <= 4; i++) begin
      call = 1'b1;
      target = 8'(i * 16);
      tick();
      idle();
    end
    vec++;
    if (pc !== 8'h40 || sp !== 3'd4 || stack_full !== 1'b1 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill got %h/%0d/%b/%b exp 40/4/1/0", pc, sp, stack_full, err_ovf);
    end
    call = 1'b1;
    target = 8'h50;
    tick();
    idle();
    vec++;
    if (sp !== 3'd4 || stack_full !== 1'b1 || err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf got %0d/%b/%b exp 4/1/1", sp, stack_full, err_ovf);
    end
    vec++;
    if (pc !== (TR ? 8'hF0 : 8'h50) || trap !== TR) begin
      bad++;
      $display("FAIL ovf_pc got %h/%b exp %h/%b", pc, trap, TR ? 8'hF0 : 8'h50, TR);
    end
    tick();
    vec++;
    if (trap !== 1'b0 || err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_after got trap %b ovf %b exp 0/1", trap, err_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1;
      tick();
      idle();
      vec++;
      if (pc !== rets[i] || sp !== 3'(3 - i)) begin
        bad++;
        $display("FAIL unwind[%0d] got %h/%0d exp %h/%0d", i, pc, sp, rets[i], 3 - i);
      end
    end
    vec++;
    if (stack_empty !== 1'b1 || err_unf !== 1'b0) begin
      bad++;
      $display("FAIL unwind_end got %b/%b exp 1/0", stack_empty, err_unf);
    end
  endtask

  task automatic test_underflow_reset();
    go_to(8'h30);
    ret = 1'b1;
    tick();
    idle();
    vec++;
    if (err_unf !== 1'b1 || sp !== 3'd0 || err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL unf got %b/%0d/%b exp 1/0/1", err_unf, sp, err_ovf);
    end
    vec++;
    if (pc !== (TR ? 8'hF0 : 8'h31) || trap !== TR) begin
      bad++;
      $display("FAIL unf_pc got %h/%b exp %h/%b", pc, trap, TR ? 8'hF0 : 8'h31, TR);
    end
    call = 1'b1;
    target = 8'h90;
    tick();
    idle();
    #2;
    reset = 1'b0;
    #1;
    vec++;
    if (pc !== 8'h00 || sp !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got %h/%0d/%b/%b exp 00/0/1/0", pc, sp, stack_empty, stack_full);
    end
    vec++;
    if ({err_ovf, err_unf, trap} !== 3'b000) begin
      bad++;
      $display("FAIL async_err got %b exp 000", {err_ovf, err_unf, trap});
    end
    tick();
    reset = 1'b1;
    tick();
    vec++;
    if (pc !== 8'h01) begin
      bad++;
      $display("FAIL post_rst got %h exp 01", pc);
    end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    reset = 1'b0;
    idle();
    target = '0;
    offset = '0;
    test_reset();
    test_increment();
    test_branch();
    test_stall();
    test_call_ret();
    test_priority();
    test_overflow();
    test_underflow_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
